// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: comparator bit indices and fetch address-map defaults
package fetch_pc_pkg;
    localparam logic [2:0] CMP_EQUAL  = 3'd0;
    localparam logic [2:0] CMP_NEQUAL = 3'd1;
    localparam logic [2:0] CMP_RSLTZ  = 3'd2;
    localparam logic [2:0] CMP_RSLEZ  = 3'd3;
    localparam logic [2:0] CMP_RSGTZ  = 3'd4;
    localparam logic [2:0] CMP_RSGEZ  = 3'd5;
    localparam logic [31:0] PC_START_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int IM_WORDS_DEF = 4096;
endpackage

// File: rtl/fetch_pc_npc_sel.sv
// npc_sel: branch/jump target generation and next-PC priority mux
module npc_sel
    import fetch_pc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] dPc,
    input  logic [25:0] dInstr,
    input  logic [7:0]  cmp,
    input  logic        brEn,
    input  logic [2:0]  brCond,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] ra,
    output logic [31:0] npc
);
    logic [31:0] dSeq;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
    logic        taken;
    assign dSeq     = dPc + 32'd4;
    assign brTarget = dSeq + {{14{dInstr[15]}}, dInstr[15:0], 2'b00};
    assign jTarget  = {dSeq[31:28], dInstr, 2'b00};
    // conditions 6 and 7 name no comparator result, so they never branch
    assign taken    = brEn && (brCond <= CMP_RSGEZ) && cmp[brCond];
    assign npc      = jr ? ra : jump ? jTarget : taken ? brTarget : pc + 32'd4;
endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: F-stage PC register and F/D pipeline register with delay slot
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] PC_START = PC_START_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int          IM_WORDS = IM_WORDS_DEF
) (
    input  logic        iclk,
    input  logic        ireset_n,
    input  logic        istall,
    input  logic [31:0] iinstr,
    input  logic [7:0]  icmp,
    input  logic        ibr_en,
    input  logic [2:0]  ibr_cond,
    input  logic        ijump,
    input  logic        ijr,
    input  logic [31:0] ira,
    output logic [31:0] opc,
    output logic [31:0] oD_instr,
    output logic [31:0] oD_pc,
    output logic [31:0] oD_pc8,
    output logic        oD_valid,
    output logic        oadel
);
    localparam logic [31:0] IM_LAST = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;
    logic [31:0] npc;
    npc_sel uNpcSel (
        .pc(opc), .dPc(oD_pc), .dInstr(oD_instr[25:0]), .cmp(icmp),
        .brEn(ibr_en), .brCond(ibr_cond), .jump(ijump), .jr(ijr),
        .ra(ira), .npc(npc)
    );
    assign oadel  = (opc[1:0] != 2'b00) || (opc < IM_BASE) || (opc > IM_LAST);
    assign oD_pc8 = oD_pc + 32'd8;
    // an illegal fetch enters D as a bubble; the PC keeps advancing
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            opc      <= PC_START;
            oD_instr <= 32'h0;
            oD_pc    <= 32'h0;
            oD_valid <= 1'b0;
        end else if (!istall) begin
            opc      <= npc;
            oD_instr <= oadel ? 32'h0 : iinstr;
            oD_pc    <= opc;
            oD_valid <= !oadel;
        end
    end
endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed and randomized checks of fetch_pc against a reference model
module tb_fetch_pc;
    logic        iclk = 1'b0;
    logic        ireset_n = 1'b0;
    logic        istall = 1'b0;
    logic [31:0] iinstr = '0;
    logic [7:0]  icmp = '0;
    logic        ibr_en = 1'b0;
    logic [2:0]  ibr_cond = '0;
    logic        ijump = 1'b0;
    logic        ijr = 1'b0;
    logic [31:0] ira = '0;
    logic [31:0] opc, oD_instr, oD_pc, oD_pc8;
    logic        oD_valid, oadel;
    int errors = 0;
    int checks = 0;
    logic [31:0] mPc, mDInstr, mDPc;
    logic        mDValid;

    fetch_pc dut (
        .iclk(iclk), .ireset_n(ireset_n), .istall(istall), .iinstr(iinstr),
        .icmp(icmp), .ibr_en(ibr_en), .ibr_cond(ibr_cond), .ijump(ijump),
        .ijr(ijr), .ira(ira), .opc(opc), .oD_instr(oD_instr), .oD_pc(oD_pc),
        .oD_pc8(oD_pc8), .oD_valid(oD_valid), .oadel(oadel)
    );

    always #5 iclk = ~iclk;

    function automatic logic illegal(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a >= 32'h3000 + 4 * 4096);
    endfunction

    task automatic modelInit();
        mPc = 32'h3000;
        mDInstr = 0;
        mDPc = 0;
        mDValid = 0;
    endtask

    task automatic step(input logic [31:0] instr, input logic stall, input logic br,
                        input logic [2:0] cond, input logic [7:0] cmp,
                        input logic jmp, input logic jr, input logic [31:0] ra);
        logic [31:0] nPc;
        int off;
        iinstr = instr; istall = stall; ibr_en = br; ibr_cond = cond;
        icmp = cmp; ijump = jmp; ijr = jr; ira = ra;
        off = 4 * int'($signed(mDInstr[15:0]));
        if (jr) nPc = ra;
        else if (jmp) nPc = ((mDPc + 4) & 32'hF000_0000) | ((mDInstr & 32'h03FF_FFFF) * 4);
        else if (br && cond < 6 && cmp[cond]) nPc = mDPc + 4 + 32'(off);
        else nPc = mPc + 4;
        @(posedge iclk);
        #1;
        if (!stall) begin
            mDInstr = illegal(mPc) ? 32'h0 : instr;
            mDValid = !illegal(mPc);
            mDPc = mPc;
            mPc = nPc;
        end
    endtask

    task automatic idle(input logic [31:0] instr);
        step(instr, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        ireset_n = 0;
        istall = 1;
        #2;
        @(negedge iclk);
        ireset_n = 1;
        @(posedge iclk);
        #1;
        istall = 0;
        modelInit();
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (opc !== 32'h3000 || oD_instr !== 0 || oD_pc !== 0 || oD_pc8 !== 32'h8 ||
            oD_valid !== 0 || oadel !== 0) begin
            errors++;
            $display("FAIL reset: opc=%h instr=%h pc=%h pc8=%h valid=%b adel=%b expected 3000/0/0/8/0/0",
                     opc, oD_instr, oD_pc, oD_pc8, oD_valid, oadel);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] expPc [3] = '{32'h3004, 32'h3008, 32'h300C};
        doReset();
        for (int i = 0; i < 3; i++) begin
            idle(32'h1000_0000 + i);
            checks++;
            if (opc !== expPc[i] || oD_pc !== expPc[i] - 4 || oD_valid !== 1 ||
                oD_instr !== 32'h1000_0000 + i) begin
                errors++;
                $display("FAIL seq%0d: opc=%h pc=%h valid=%b instr=%h expected opc=%h pc=%h valid=1",
                         i, opc, oD_pc, oD_valid, oD_instr, expPc[i], expPc[i] - 4);
            end
        end
    endtask

    task automatic test_branch(input logic takenCase);
        logic [31:0] want;
        doReset();
        for (int i = 0; i < 4; i++) idle(0);
        idle({6'b000100, 10'd0, 16'h0004});
        step(32'hAAAA_0001, 0, 1, 3'd0, {7'd0, takenCase}, 0, 0, 0);
        want = takenCase ? 32'h3024 : 32'h3018;
        checks++;
        if (opc !== want || oD_pc !== 32'h3014 || oD_instr !== 32'hAAAA_0001 || oD_valid !== 1) begin
            errors++;
            $display("FAIL beq taken=%b: opc=%h dpc=%h dinstr=%h expected opc=%h dpc=3014",
                     takenCase, opc, oD_pc, oD_instr, want);
        end
        idle(32'hBBBB_0002);
        checks++;
        if (oD_pc !== want || opc !== want + 4) begin
            errors++;
            $display("FAIL beq target in D: dpc=%h opc=%h expected %h/%h", oD_pc, opc, want, want + 4);
        end
    endtask

    task automatic test_stall();
        doReset();
        for (int i = 0; i < 8; i++) idle(0);
        idle({6'b000101, 10'd0, 16'hFFFF});
        step(32'hCCCC_0003, 1, 1, 3'd1, 8'h02, 0, 0, 0);
        checks++;
        if (opc !== 32'h3024 || oD_pc !== 32'h3020 || oD_instr !== {6'b000101, 10'd0, 16'hFFFF} ||
            oD_valid !== 1) begin
            errors++;
            $display("FAIL stall hold: opc=%h dpc=%h dinstr=%h expected 3024/3020/1400ffff",
                     opc, oD_pc, oD_instr);
        end
        step(32'hCCCC_0003, 0, 1, 3'd1, 8'h02, 0, 0, 0);
        checks++;
        if (opc !== 32'h3020 || oD_pc !== 32'h3024 || oD_instr !== 32'hCCCC_0003) begin
            errors++;
            $display("FAIL stall release: opc=%h dpc=%h expected 3020/3024", opc, oD_pc);
        end
    endtask

    task automatic test_jr_adel();
        doReset();
        idle(0);
        step(32'hDDDD_0004, 0, 0, 0, 0, 0, 1, 32'h0000_3101);
        checks++;
        if (opc !== 32'h3101 || oadel !== 1) begin
            errors++;
            $display("FAIL jr: opc=%h adel=%b expected 3101/1", opc, oadel);
        end
        idle(32'hEEEE_0005);
        checks++;
        if (oD_valid !== 0 || oD_instr !== 0 || oD_pc !== 32'h3101 || opc !== 32'h3105) begin
            errors++;
            $display("FAIL adel bubble: valid=%b instr=%h dpc=%h opc=%h expected 0/0/3101/3105",
                     oD_valid, oD_instr, oD_pc, opc);
        end
    endtask

    task automatic test_jal();
        doReset();
        idle({6'b000011, 26'h0000C40});
        checks++;
        if (oD_pc8 !== 32'h3008 || oD_pc !== 32'h3000) begin
            errors++;
            $display("FAIL jal link: pc8=%h dpc=%h expected 3008/3000", oD_pc8, oD_pc);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (opc !== 32'h3100) begin
            errors++;
            $display("FAIL jal target: opc=%h expected 3100", opc);
        end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        for (int i = 0; i < 20; i++) idle(32'h1234_0000 + i);
        checks++;
        if (opc !== 32'h3050) begin
            errors++;
            $display("FAIL pre-reset opc: opc=%h expected 3050", opc);
        end
        istall = 1;
        #2;
        ireset_n = 0;
        #1;
        checks++;
        if (opc !== 32'h3000 || oD_valid !== 0 || oD_instr !== 0 || oD_pc !== 0 || oD_pc8 !== 8) begin
            errors++;
            $display("FAIL async reset: opc=%h valid=%b instr=%h dpc=%h pc8=%h expected 3000/0/0/0/8",
                     opc, oD_valid, oD_instr, oD_pc, oD_pc8);
        end
        @(negedge iclk);
        ireset_n = 1;
        @(posedge iclk);
        #1;
        istall = 0;
        modelInit();
    endtask

    task automatic test_cond67();
        doReset();
        for (int i = 0; i < 3; i++) idle({6'b000100, 10'd0, 16'h0010});
        step(0, 0, 1, 3'd6, 8'hFF, 0, 0, 0);
        checks++;
        if (opc !== 32'h3010) begin
            errors++;
            $display("FAIL cond6: opc=%h expected 3010", opc);
        end
        step(0, 0, 1, 3'd7, 8'hFF, 0, 0, 0);
        checks++;
        if (opc !== 32'h3014) begin
            errors++;
            $display("FAIL cond7: opc=%h expected 3014", opc);
        end
    endtask

    task automatic test_random();
        logic [31:0] instr, ra;
        logic stall, br, jmp, jr;
        int kind;
        doReset();
        for (int i = 0; i < 400; i++) begin
            kind = int'($urandom_range(0, 9));
            stall = ($urandom_range(0, 4) == 0);
            br = (kind < 3) || kind == 9;
            jmp = (kind == 3) || kind == 9;
            jr = (kind == 4) || kind == 9;
            instr = $urandom;
            instr[15] = ($urandom_range(0, 3) == 0);
            instr[25:20] = 6'h0;
            instr[19:16] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'h0;
            instr[11:10] = 2'b00;
            ra = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(0, 4095);
            step(instr, stall, br, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 63)), jmp, jr, ra);
            checks++;
            if (opc !== mPc || oD_instr !== mDInstr || oD_pc !== mDPc || oD_pc8 !== mDPc + 8 ||
                oD_valid !== mDValid || oadel !== illegal(mPc)) begin
                errors++;
                $display("FAIL random%0d: opc=%h instr=%h dpc=%h pc8=%h valid=%b adel=%b expected %h/%h/%h/%h/%b/%b",
                         i, opc, oD_instr, oD_pc, oD_pc8, oD_valid, oadel,
                         mPc, mDInstr, mDPc, mDPc + 8, mDValid, illegal(mPc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch(1);
        test_branch(0);
        test_stall();
        test_jr_adel();
        test_jal();
        test_reset_mid_stall();
        test_cond67();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program counter and F/D pipeline register for the five-stage MIPS core. It holds the F-stage PC, selects the next PC from the D-stage branch/jump decision, and latches the fetched instruction and its PC into the D stage. The branch decision consumes the comparator result vector produced in D, so this block sits directly downstream of the comparator. It honours the hazard-unit stall and implements the architectural one-instruction delay slot.

## Interface
Parameters:
- PC_START, 32'h0000_3000, PC value loaded on reset
- IM_BASE, 32'h0000_3000, lowest legal fetch address
- IM_WORDS, 4096, instruction-memory depth in words (legal range IM_BASE to IM_BASE+4*IM_WORDS-4)

Ports:
- iclk  input  1  clock, all state updates on rising edge
- ireset_n  input  1  asynchronous active-low reset
- istall  input  1  hazard-unit stall: freeze PC and the F/D register
- iinstr  input  32  instruction read combinationally from IM at opc
- icmp  input  8  comparator result vector for the D-stage operands
- ibr_en  input  1  D-stage instruction is a conditional branch
- ibr_cond  input  3  index of the icmp bit that decides the branch (0..5)
- ijump  input  1  D-stage instruction is j/jal
- ijr  input  1  D-stage instruction is jr/jalr
- ira  input  32  forwarded rs value for jr/jalr
- opc  output  32  F-stage PC (IM address)
- oD_instr  output  32  D-stage instruction
- oD_pc  output  32  D-stage PC
- oD_pc8  output  32  oD_pc + 8 (link address)
- oD_valid  output  1  D-stage slot holds a fetched instruction
- oadel  output  1  opc misaligned or outside the IM range (combinational on opc)

## Operation
- Comparator bit indices (icmp): 0 equal, 1 not-equal, 2 rs<0, 3 rs<=0, 4 rs>0, 5 rs>=0; bits 7:6 always zero and never selected. ibr_cond of 6 or 7 means branch not taken.
- Branch taken = ibr_en & icmp[ibr_cond].
- Targets, all based on oD_pc (branch/jump in D):
  - branch: oD_pc + 4 + (sign-extend(oD_instr[15:0]) << 2), 32-bit wrap-around, no overflow signalling
  - j/jal: {oD_pc+4 [31:28], oD_instr[25:0], 2'b00}
  - jr/jalr: ira unchanged (misalignment reported later via oadel)
- Next PC priority: istall (hold) > ijr > ijump > branch taken > opc + 4. Decode guarantees at most one of ibr_en/ijump/ijr; if several assert, the priority above is used.
- Delay slot: when D redirects, the instruction currently at opc (delay slot) is still latched into D; the redirect target becomes the new opc. No flush exists.
- F/D register on non-stalled edge: oD_instr<=iinstr, oD_pc<=opc, oD_valid<=1. If oadel is high, oD_instr<=32'h0 (nop) and oD_valid<=0 instead.
- Stall: opc, oD_instr, oD_pc, oD_valid all hold; redirect is ignored that cycle and re-evaluated next cycle (operands come from hazard-resolved forwarding).
- oadel = (opc[1:0]!=0) | opc<IM_BASE | opc>IM_BASE+4*IM_WORDS-4. The PC still advances normally after an illegal address.

## Timing
- Reset (async assert, any time including mid-stall): opc=PC_START, oD_instr=0, oD_pc=0, oD_valid=0; oD_pc8=8; oadel=0 for default parameters.
- First non-stalled edge after release: D holds instruction at PC_START, opc=PC_START+4.
- Redirect latency: branch in D at cycle n -> delay slot enters D and opc=target at edge n+1; target instruction enters D at edge n+2.
- Next-PC path is combinational from icmp/ira to the PC register D-input; no registered branch prediction.

## Structure
- Shared define file: comparator bit indices (CMP_EQUAL..CMP_RSGEZ), PC_START/IM_BASE/IM_WORDS defaults.
- One combinational sub-module `npc_sel` (targets + priority mux); registers stay in `fetch_pc`.

## Test plan
- Reset then 3 free-running cycles -> opc 0x3000, 0x3004, 0x3008, 0x300C; oD_pc trails by one, oD_valid 0 then 1.
- beq in D at 0x3010, imm=0x0004, icmp[0]=1, ibr_cond=0 -> delay slot 0x3014 enters D, next opc 0x3024; with icmp[0]=0 -> opc 0x3018.
- bne with imm=0xFFFF (-1) at 0x3020, taken -> opc 0x3020; istall high that cycle -> opc, oD_* unchanged, redirect applied next cycle.
- jr with ira=0x0000_3101 -> opc 0x3101, oadel=1, following D slot nop with oD_valid=0; jal index 0x0000C40 at 0x3000 -> opc 0x3100, oD_pc8=0x3008.
- ireset_n pulsed low mid-stall with opc 0x3050 -> immediately opc 0x3000, oD_valid 0, all D outputs reset before next edge.
- ibr_cond=6 with ibr_en=1, icmp=8'hFF -> not taken, opc+4.
